// File: rtl/gb_bus_responder.sv
// gb_bus_responder: CPU bus responder with local HRAM/IE/IF and an external req/ack port (optional timeout via GB_BUS_TIMEOUT_EN)
module gb_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [7:0]  OPEN_BUS_DATA  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        ext_req,
    output logic [15:0] ext_addr,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    input  logic [4:0]  irq_pulse,
    output logic [7:0]  ie_o,
    output logic [4:0]  if_o
);
    typedef enum logic [1:0] {IDLE, LOCAL_RESP, EXT_WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [7:0] hram [0:126];
    logic       accept, is_hram, is_if, is_ie, is_local, ext_done;
    logic [7:0] local_rdata, done_rdata;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || $bits(OPEN_BUS_DATA) != 8) begin : g_bad_param
        $error("gb_bus_responder: TIMEOUT_CYCLES must be 1..255 and OPEN_BUS_DATA 8 bits");
    end

    assign accept      = state == IDLE && req_valid;
    assign is_hram     = req_addr[15:7] == 9'h1FF && req_addr[6:0] != 7'h7F;
    assign is_if       = req_addr == 16'hFF0F;
    assign is_ie       = req_addr == 16'hFFFF;
    assign is_local    = is_hram || is_if || is_ie;
    assign local_rdata = is_ie ? ie_o : is_if ? {3'b111, if_o} : is_hram ? hram[req_addr[6:0]] : 8'h00;

`ifdef GB_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    assign timeout    = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
    assign ext_done   = ext_ack || timeout;
    assign done_rdata = ext_we ? 8'h00 : ext_ack ? ext_rdata : OPEN_BUS_DATA;

    // count cycles spent waiting on the external side; cleared whenever not waiting
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wait_cnt <= '0;
        else        wait_cnt <= state == EXT_WAIT ? wait_cnt + 8'd1 : 8'd0;
`else
    assign ext_done   = ext_ack;
    assign done_rdata = ext_we ? 8'h00 : ext_rdata;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // next state and handshake outputs decoded from the current state
    always_comb begin
        state_nxt  = state;
        resp_valid = state == LOCAL_RESP || state == RESP;
        ext_req    = state == EXT_WAIT;
        unique case (state)
            IDLE:       state_nxt = accept ? (is_local ? LOCAL_RESP : EXT_WAIT) : IDLE;
            LOCAL_RESP: state_nxt = IDLE;
            EXT_WAIT:   state_nxt = ext_done ? RESP : EXT_WAIT;
            RESP:       state_nxt = IDLE;
        endcase
    end

    // capture the accepted request and the response data (local at accept, external at completion)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ext_addr   <= '0;
            ext_we     <= 1'b0;
            ext_wdata  <= '0;
            resp_rdata <= '0;
        end else if (accept) begin
            ext_addr   <= req_addr;
            ext_we     <= req_we;
            ext_wdata  <= req_wdata;
            resp_rdata <= req_we ? 8'h00 : local_rdata;
        end else if (state == EXT_WAIT && ext_done) begin
            resp_rdata <= done_rdata;
        end

    // IE/IF registers; interrupt pulses override a same-cycle CPU write bit by bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ie_o <= '0;
            if_o <= '0;
        end else begin
            if (accept && req_we && is_ie) ie_o <= req_wdata;
            if_o <= (accept && req_we && is_if ? req_wdata[4:0] : if_o) | irq_pulse;
        end

    // HRAM storage, intentionally not reset
    always_ff @(posedge clk)
        if (accept && req_we && is_hram) hram[req_addr[6:0]] <= req_wdata;
endmodule

// File: tb/tb_gb_bus_responder.sv
// tb_gb_bus_responder: directed self-checking bench for gb_bus_responder
module tb_gb_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [7:0]  req_wdata = '0;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        ext_req;
    logic [15:0] ext_addr;
    logic        ext_we;
    logic [7:0]  ext_wdata;
    logic        ext_ack = 1'b0;
    logic [7:0]  ext_rdata = '0;
    logic [4:0]  irq_pulse = '0;
    logic [7:0]  ie_o;
    logic [4:0]  if_o;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  rd;

    always #5 clk = ~clk;

    gb_bus_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_we(ext_we), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .irq_pulse(irq_pulse), .ie_o(ie_o), .if_o(if_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic local_acc(input string tag, input logic [15:0] a, input logic we, input logic [7:0] wd);
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
        tick();
        chk({tag, "_valid"}, resp_valid, 1);
        rd = resp_rdata;
        req_valid = 1'b0;
        tick();
        chk({tag, "_idle"}, resp_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ext_req", ext_req, 0);
        chk("rst_ext_addr", ext_addr, 0);
        chk("rst_ext_we", ext_we, 0);
        chk("rst_ext_wdata", ext_wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_ie", ie_o, 0);
        chk("rst_if", if_o, 0);
        rst_n = 1'b1;
        tick();

        local_acc("hram_wr", 16'hFF80, 1'b1, 8'hA5);
        chk("hram_wr_rdata", rd, 8'h00);
        local_acc("hram_rd", 16'hFF80, 1'b0, 8'h00);
        chk("hram_rd_rdata", rd, 8'hA5);
        local_acc("hram_top_wr", 16'hFFFE, 1'b1, 8'h5A);
        local_acc("hram_top_rd", 16'hFFFE, 1'b0, 8'h00);
        chk("hram_top_rdata", rd, 8'h5A);
        local_acc("hram_rd2", 16'hFF80, 1'b0, 8'h00);
        chk("hram_rd2_rdata", rd, 8'hA5);

        local_acc("ie_wr", 16'hFFFF, 1'b1, 8'h1F);
        chk("ie_o", ie_o, 8'h1F);
        local_acc("ie_rd", 16'hFFFF, 1'b0, 8'h00);
        chk("ie_rd_rdata", rd, 8'h1F);

        req_valid = 1'b1; req_addr = 16'hFF0F; req_we = 1'b1; req_wdata = 8'h00;
        irq_pulse = 5'b00100;
        tick();
        irq_pulse = 5'b00000;
        chk("if_wr_valid", resp_valid, 1);
        req_valid = 1'b0;
        tick();
        chk("if_irq_wins", if_o, 5'b00100);
        local_acc("if_rd", 16'hFF0F, 1'b0, 8'h00);
        chk("if_rd_rdata", rd, 8'hE4);
        local_acc("if_wr_ff", 16'hFF0F, 1'b1, 8'hFF);
        chk("if_mask", if_o, 5'h1F);
        local_acc("if_rd_ff", 16'hFF0F, 1'b0, 8'h00);
        chk("if_rd_ff_rdata", rd, 8'hFF);
        local_acc("if_clr", 16'hFF0F, 1'b1, 8'h00);
        chk("if_cleared", if_o, 5'h00);
        irq_pulse = 5'b10001;
        tick();
        irq_pulse = 5'b00000;
        chk("if_idle_irq", if_o, 5'b10001);
        tick();
        chk("if_sticky", if_o, 5'b10001);

        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        chk("stray_ack_resp", resp_valid, 0);
        chk("stray_ack_ext_req", ext_req, 0);

        req_valid = 1'b1; req_addr = 16'hC000; req_we = 1'b0; req_wdata = 8'h00;
        tick();
        chk("ext_rd_req_c1", ext_req, 1);
        chk("ext_rd_addr", ext_addr, 16'hC000);
        chk("ext_rd_we", ext_we, 0);
        chk("ext_rd_resp_c1", resp_valid, 0);
        tick();
        chk("ext_rd_req_c2", ext_req, 1);
        tick();
        chk("ext_rd_req_c3", ext_req, 1);
        chk("ext_rd_resp_c3", resp_valid, 0);
        ext_ack = 1'b1; ext_rdata = 8'h3C;
        tick();
        ext_ack = 1'b0; ext_rdata = 8'h00; req_valid = 1'b0;
        chk("ext_rd_req_done", ext_req, 0);
        chk("ext_rd_resp", resp_valid, 1);
        chk("ext_rd_rdata", resp_rdata, 8'h3C);
        tick();
        chk("ext_rd_idle", resp_valid, 0);

        req_valid = 1'b1; req_addr = 16'h1234; req_we = 1'b1; req_wdata = 8'h77;
        tick();
        chk("ext_wr_req", ext_req, 1);
        chk("ext_wr_we", ext_we, 1);
        chk("ext_wr_wdata", ext_wdata, 8'h77);
        ext_ack = 1'b1; ext_rdata = 8'hAA;
        tick();
        ext_ack = 1'b0; ext_rdata = 8'h00; req_valid = 1'b0;
        chk("ext_wr_resp", resp_valid, 1);
        chk("ext_wr_rdata", resp_rdata, 8'h00);
        chk("ext_wr_req_done", ext_req, 0);
        tick();
        chk("ext_wr_idle", resp_valid, 0);

`ifdef GB_BUS_TIMEOUT_EN
        begin
            int n;
            n = 0;
            req_valid = 1'b1; req_addr = 16'h8000; req_we = 1'b0;
            tick();
            while (ext_req && n < 40) begin
                n++;
                tick();
            end
            chk("to_req_cycles", n, 15);
            chk("to_resp", resp_valid, 1);
            chk("to_rdata", resp_rdata, 8'hFF);
            req_valid = 1'b0;
            tick();
            req_valid = 1'b1; req_addr = 16'h8000; req_we = 1'b0;
            tick();
            repeat (14) tick();
            chk("to_ack_req", ext_req, 1);
            ext_ack = 1'b1; ext_rdata = 8'h5C;
            tick();
            ext_ack = 1'b0; ext_rdata = 8'h00; req_valid = 1'b0;
            chk("to_ack_resp", resp_valid, 1);
            chk("to_ack_rdata", resp_rdata, 8'h5C);
            tick();
        end
`endif

        irq_pulse = 5'b00011;
        tick();
        irq_pulse = 5'b00000;
        chk("pre_rst_if", if_o, 5'b10011);
        req_valid = 1'b1; req_addr = 16'hC000; req_we = 1'b0;
        tick();
        chk("pre_rst_ext_req", ext_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ext_req", ext_req, 0);
        chk("async_rst_ie", ie_o, 0);
        chk("async_rst_if", if_o, 0);
        chk("async_rst_resp", resp_valid, 0);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_resp", resp_valid, 0);
            chk("post_rst_ext_req", ext_req, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gb_bus_responder.md
GB_BUS_RESPONDER -- requirements
Module: gb_bus_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of EXT_WAIT cycles before abort (range 1..255).
REQ-002 SHALL have parameter OPEN_BUS_DATA, default 8'hFF, meaning the read data returned on timeout.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  CPU request strobe; held until resp_valid is seen.
REQ-006 req_addr  in  16  request address.
REQ-007 req_we  in  1  1=write, 0=read.
REQ-008 req_wdata  in  8  write data.
REQ-009 resp_valid  out  1  one-cycle completion pulse.
REQ-010 resp_rdata  out  8  read data; valid only with resp_valid.
REQ-011 ext_req  out  1  external request; held high through EXT_WAIT.
REQ-012 ext_addr, ext_we, ext_wdata  out  16/1/8  registered copies of the accepted request.
REQ-013 ext_ack  in  1  external completion; ignored outside EXT_WAIT.
REQ-014 ext_rdata  in  8  external read data; sampled with ext_ack.
REQ-015 irq_pulse  in  5  per-source interrupt set strobes (VBlank, STAT, Timer, Serial, Joypad).
REQ-016 ie_o  out  8  IE register contents.
REQ-017 if_o  out  5  IF register contents.

Function
REQ-018 SHALL decode three local regions: HRAM 16'hFF80-16'hFFFE (127x8 storage), IF at 16'hFF0F, and IE at 16'hFFFF; all other addresses are external.
REQ-019 SHALL implement the FSM IDLE -> LOCAL_RESP -> IDLE for local accesses, and IDLE -> EXT_WAIT -> RESP -> IDLE for external accesses.
REQ-020 IDLE SHALL accept a request when req_valid=1 and register addr/we/wdata.
REQ-021 Local accesses SHALL assert resp_valid exactly one cycle after acceptance (latency 1).
REQ-022 Local writes SHALL update storage on the acceptance edge.
REQ-023 Local reads SHALL return data from before any same-cycle write.
REQ-024 IF reads SHALL return {3'b111, if[4:0]}; IF writes SHALL store wdata[4:0] only.
REQ-025 External accesses SHALL raise ext_req the cycle after acceptance and hold it until ext_ack.
REQ-026 On ext_ack, the block SHALL latch ext_rdata, drop ext_req, and enter RESP.
REQ-027 RESP SHALL pulse resp_valid for one cycle with the latched data; rdata SHALL be 8'h00 for writes.
REQ-028 After resp_valid, the block SHALL spend one cycle in IDLE before accepting the next request, so back-to-back throughput is one request per 2 cycles (local).
REQ-029 irq_pulse bits SHALL set IF bits every cycle in any state.
REQ-030 When a CPU write to IF coincides with irq_pulse, the pulse SHALL win per bit: new_if = wdata[4:0] | irq_pulse.
REQ-031 An ext_ack arriving in the same cycle ext_req first asserts SHALL be honoured (minimum external latency 2 cycles to resp_valid).
REQ-032 req_valid deasserted mid-transaction is illegal; the block SHALL complete the transaction regardless.

Reset
REQ-033 On rst_n low, the FSM SHALL go to IDLE and resp_valid, ext_req, ext_we SHALL be 0; ext_addr, ext_wdata, and resp_rdata SHALL be 0; IE SHALL be 8'h00; IF SHALL be 5'h00.
REQ-034 HRAM contents SHALL NOT be reset.
REQ-035 Reset asserted during EXT_WAIT SHALL drop ext_req asynchronously, and no resp_valid SHALL follow.

Configuration
REQ-036 With GB_BUS_TIMEOUT_EN defined, an 8-bit counter SHALL run in EXT_WAIT.
REQ-037 With GB_BUS_TIMEOUT_EN defined, after TIMEOUT_CYCLES cycles without ext_ack the block SHALL drop ext_req, enter RESP, and return OPEN_BUS_DATA (8'h00 for writes).
REQ-038 With GB_BUS_TIMEOUT_EN defined, an ext_ack arriving in the same cycle as the timeout SHALL take precedence.
REQ-039 Without GB_BUS_TIMEOUT_EN, EXT_WAIT SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-040 Write 8'hA5 to 16'hFF80, then read 16'hFF80 -> each resp_valid arrives 1 cycle after acceptance; the read returns 8'hA5.
REQ-041 Write 8'h1F to IE, then read -> ie_o=8'h1F and the read returns 8'h1F.
REQ-042 Write 8'h00 to IF while irq_pulse=5'b00100 -> if_o=5'b00100; a subsequent read of IF returns 8'hE4.
REQ-043 Read 16'hC000 with ext_ack after 3 cycles and ext_rdata=8'h3C -> ext_req is high for 3 cycles, then resp_valid with 8'h3C.
REQ-044 With GB_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=15, read 16'h8000 with no ext_ack -> resp_valid with 8'hFF; ext_req drops after 15 cycles.
REQ-045 Assert rst_n low during EXT_WAIT -> ext_req=0 immediately; no resp_valid; IE and IF are cleared.
